// File: rtl/fifo_sel_arb.sv
// fifo_sel_arb: FIFO request arbiter with grant hold, round-robin, hold timeout and legacy select code
//   glb_clk    in   system clock (rising edge)
//   glb_rst    in   synchronous active-high reset
//   arb_en     in   1 = new grants allowed; an existing grant runs until released
//   fifo_req   in   level request per FIFO
//   sel_valid  out  a grant is active
//   sel_idx    out  granted port index, 0 when idle
//   sel_code   out  8'd128 + sel_idx when valid, else 0
//   sel_change out  one-cycle pulse when {sel_valid, sel_idx} takes a new value
module fifo_sel_arb #(
    parameter int PORT_NUM = 8,
    parameter int IDX_W    = 3,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic                glb_clk,
    input  logic                glb_rst,
    input  logic                arb_en,
    input  logic [PORT_NUM-1:0] fifo_req,
    output logic                sel_valid,
    output logic [IDX_W-1:0]    sel_idx,
    output logic [7:0]          sel_code,
    output logic                sel_change
);
    localparam int HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HMAX = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [IDX_W-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;
    logic [PORT_NUM-1:0] others;
    logic [IDX_W-1:0] w_all, w_oth, start;
    logic timeout;
    // Scan offsets from the top down so the last hit is the nearest one above the start point.
    function automatic logic [IDX_W-1:0] win(input logic [PORT_NUM-1:0] r, input logic [IDX_W-1:0] p);
        int j;
        win = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= PORT_NUM) j = j - PORT_NUM;
            if (r[j]) win = IDX_W'(j);
        end
    endfunction
    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] k);
        nxt = (k == IDX_W'(PORT_NUM - 1)) ? '0 : k + IDX_W'(1);
    endfunction
    always_comb begin
        start   = (RR_MODE != 0) ? rr_ptr : '0;
        others  = fifo_req & ~(PORT_NUM'(1) << sel_idx);
        w_all   = win(fifo_req, start);
        w_oth   = win(others, start);
        timeout = (MAX_HOLD > 0) && (hold_cnt == HW'(HMAX));
    end
    assign sel_code = sel_valid ? 8'd128 + 8'(sel_idx) : 8'd0;
    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            state      <= IDLE;
            sel_valid  <= 1'b0;
            sel_idx    <= '0;
            sel_change <= 1'b0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
        end else begin
            sel_change <= 1'b0;
            case (state)
                IDLE: if (arb_en && |fifo_req) begin
                    state      <= GRANT;
                    sel_valid  <= 1'b1;
                    sel_idx    <= w_all;
                    sel_change <= 1'b1;
                    hold_cnt   <= '0;
                    rr_ptr     <= nxt(w_all);
                end
                GRANT: if (!fifo_req[sel_idx]) begin
                    // Release: the released port cannot win, so a regrant is always a new index.
                    sel_change <= 1'b1;
                    hold_cnt   <= '0;
                    if (arb_en && |others) begin
                        sel_idx <= w_all;
                        rr_ptr  <= nxt(w_all);
                    end else begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        sel_idx   <= '0;
                    end
                end else if (timeout) begin
                    hold_cnt <= '0;
                    if (arb_en && |others) begin
                        sel_idx    <= w_oth;
                        sel_change <= 1'b1;
                        rr_ptr     <= nxt(w_oth);
                    end
                end else if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_sel_arb.sv
// tb_fifo_sel_arb: directed checks of fixed, round-robin and hold-timeout arbiter variants
module tb_fifo_sel_arb;
    logic glb_clk = 0, glb_rst = 1, arb_en = 0;
    logic [7:0] req0 = 0, req1 = 0, req2 = 0;
    logic v0, v1, v2, c0, c1, c2;
    logic [2:0] i0, i1, i2;
    logic [7:0] s0, s1, s2;
    int n_cmp = 0, n_err = 0;
    always #5 glb_clk = ~glb_clk;
    fifo_sel_arb #(.PORT_NUM(8), .IDX_W(3), .RR_MODE(0), .MAX_HOLD(0)) u0 (
        .glb_clk(glb_clk), .glb_rst(glb_rst), .arb_en(arb_en), .fifo_req(req0),
        .sel_valid(v0), .sel_idx(i0), .sel_code(s0), .sel_change(c0));
    fifo_sel_arb #(.PORT_NUM(8), .IDX_W(3), .RR_MODE(1), .MAX_HOLD(0)) u1 (
        .glb_clk(glb_clk), .glb_rst(glb_rst), .arb_en(arb_en), .fifo_req(req1),
        .sel_valid(v1), .sel_idx(i1), .sel_code(s1), .sel_change(c1));
    fifo_sel_arb #(.PORT_NUM(8), .IDX_W(3), .RR_MODE(0), .MAX_HOLD(4)) u2 (
        .glb_clk(glb_clk), .glb_rst(glb_rst), .arb_en(arb_en), .fifo_req(req2),
        .sel_valid(v2), .sel_idx(i2), .sel_code(s2), .sel_change(c2));
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge glb_clk);
        #1;
    endtask
    initial begin
        step();
        step();
        glb_rst = 0;
        chk("rst_valid", v0, 0);
        chk("rst_code", s0, 0);
        chk("rst_change", c0, 0);
        arb_en = 1;
        req0 = 8'b0010_0100;
        step();
        chk("fx_valid", v0, 1);
        chk("fx_idx2", i0, 2);
        chk("fx_code130", s0, 130);
        chk("fx_chg", c0, 1);
        step();
        chk("fx_hold_idx", i0, 2);
        chk("fx_hold_chg", c0, 0);
        step();
        chk("fx_hold2_idx", i0, 2);
        req0 = 8'b0010_0000;
        step();
        chk("b2b_idx5", i0, 5);
        chk("b2b_code133", s0, 133);
        chk("b2b_valid", v0, 1);
        chk("b2b_chg", c0, 1);
        req0 = 0;
        step();
        chk("rel_valid", v0, 0);
        chk("rel_code", s0, 0);
        chk("rel_chg", c0, 1);
        step();
        chk("idle_chg", c0, 0);
        arb_en = 0;
        req0 = 8'hFF;
        step();
        chk("en0_valid_a", v0, 0);
        step();
        chk("en0_valid_b", v0, 0);
        arb_en = 1;
        step();
        chk("en1_valid", v0, 1);
        chk("en1_idx0", i0, 0);
        arb_en = 0;
        step();
        chk("en_drop_hold_v", v0, 1);
        chk("en_drop_hold_i", i0, 0);
        req0 = 8'hFE;
        step();
        chk("en_drop_rel_v", v0, 0);
        chk("en_drop_rel_code", s0, 0);
        chk("en_drop_rel_chg", c0, 1);
        req0 = 0;
        arb_en = 1;
        req1 = 8'hFF;
        step();
        chk("rr_first", i1, 0);
        chk("rr_first_v", v1, 1);
        for (int k = 1; k <= 8; k++) begin
            req1 = ~(8'd1 << ((k - 1) % 8));
            step();
            chk($sformatf("rr_seq%0d", k), i1, k % 8);
            chk($sformatf("rr_chg%0d", k), c1, 1);
        end
        req1 = 0;
        step();
        chk("rr_idle", v1, 0);
        req1 = 8'h40;
        step();
        chk("rr_g6", i1, 6);
        glb_rst = 1;
        step();
        chk("mid_rst_code", s1, 0);
        chk("mid_rst_valid", v1, 0);
        chk("mid_rst_chg", c1, 0);
        chk("mid_rst_ptr", u1.rr_ptr, 0);
        glb_rst = 0;
        step();
        chk("post_rst_v", v1, 1);
        chk("post_rst_idx6", i1, 6);
        chk("post_rst_code", s1, 134);
        req1 = 0;
        req2 = 8'b0000_1001;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("to_idx%0d", c), i2, (c < 4) ? 0 : (c < 8) ? 3 : 0);
            chk($sformatf("to_chg%0d", c), c2, (c == 0 || c == 4 || c == 8) ? 1 : 0);
        end
        req2 = 8'b0000_0001;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("solo_v%0d", c), v2, 1);
            chk($sformatf("solo_i%0d", c), i2, 0);
            chk($sformatf("solo_c%0d", c), c2, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
